pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter SRAM_WAIT, default 4, SRAM access latency in cycles (legal 1..15).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 id_src1  in  4  Rn index of instruction in ID.
REQ-005 id_use_src1  in  1  ID instruction reads Rn.
REQ-006 id_src2  in  4  Rm/Rd index of instruction in ID.
REQ-007 id_two_src  in  1  ID instruction reads second source.
REQ-008 exe_dest, exe_wb_en, exe_mem_read_en  in  4/1/1  dest, writeback enable and load flag of instruction in EXE.
REQ-009 mem_dest, mem_wb_en  in  4/1  dest and writeback enable of instruction in MEM.
REQ-010 branch_taken  in  1  branch resolved taken in EXE.
REQ-011 mem_req  in  1  MEM stage holds a load/store.
REQ-012 freeze  out  1  hold PC and IF_reg.
REQ-013 hazard  out  1  insert bubble into ID_reg (zero control bits).
REQ-014 flush  out  1  clear IF_reg and ID_reg.
REQ-015 mem_stall  out  1  hold every pipeline register.
REQ-016 sram_start  out  1  one-cycle SRAM access strobe.
REQ-017 stall_count  out  16  saturating count of cycles with freeze=1.

Function
REQ-018 Memory FSM states IDLE, BUSY, DONE; 4-bit down-counter cnt.
REQ-019 IDLE: mem_req=1 -> sram_start=1 (same cycle, combinational), cnt<=SRAM_WAIT-1, next BUSY; else stay IDLE.
REQ-020 BUSY: mem_stall=1; cnt==0 -> next DONE, else cnt<=cnt-1.
REQ-021 DONE: mem_stall=0, mem_req ignored, next IDLE unconditionally (pipeline advances one step).
REQ-022 SRAM_WAIT=1 -> BUSY lasts exactly one cycle; total access IDLE+BUSY+DONE = SRAM_WAIT+2 cycles.
REQ-023 raw = match(exe) | match(mem); match(x) = x_wb_en & ((id_use_src1 & x_dest==id_src1) | (id_two_src & x_dest==id_src2)).
REQ-024 hazard = raw & ~branch_taken & ~mem_stall.
REQ-025 flush = branch_taken & ~mem_stall (flush deferred while stalled, fires on first unstalled cycle).
REQ-026 freeze = hazard | mem_stall.
REQ-027 Decode outputs hazard/flush/freeze purely combinational; sram_start and mem_stall decoded from FSM state only plus mem_req in IDLE.
REQ-028 stall_count increments each cycle freeze=1; holds at 16'hFFFF.
REQ-029 Simultaneous branch_taken and raw: flush=1, hazard=0, freeze=0.

Reset
REQ-030 rst=1 at a rising edge: state<=IDLE, cnt<=0, stall_count<=0, overriding all other inputs including mid-BUSY.
REQ-031 While rst=1, mem_stall=0 and sram_start=0 regardless of mem_req; hazard/flush follow inputs.
REQ-032 First cycle after reset release with mem_req=1 starts a fresh access.

Configuration
REQ-033 Macro PIPE_CTRL_FWD_EN defined: match(exe) additionally requires exe_mem_read_en=1; match(mem) forced 0 (forwarding unit covers ALU results).
REQ-034 Macro undefined: REQ-023 applies unchanged (full RAW stalling).

Verification
REQ-035 SRAM_WAIT=4, mem_req=1 from cycle 0: sram_start=1 cycle 0 only, mem_stall=1 cycles 1-4, 0 at cycle 5 (DONE), IDLE cycle 6; stall_count=4.
REQ-036 id_src1=3, id_use_src1=1, exe_dest=3, exe_wb_en=1, exe_mem_read_en=0: hazard=1/freeze=1 without macro; hazard=0 with PIPE_CTRL_FWD_EN.
REQ-037 Same as REQ-036 but exe_mem_read_en=1: hazard=1 in both builds.
REQ-038 branch_taken=1 during BUSY: flush=0 until DONE cycle, flush=1 in DONE; branch_taken with raw=1 in IDLE: flush=1, hazard=0.
REQ-039 rst=1 asserted at cycle 2 of BUSY: next cycle state IDLE, mem_stall=0, stall_count=0.
REQ-040 freeze held 70000 cycles: stall_count saturates at 65535 and stays.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/stall controller with an SRAM access FSM and a saturating freeze counter.
// Optional build macro PIPE_CTRL_FWD_EN: with forwarding present, only EXE loads cause RAW stalls.
module pipe_ctrl #(
  parameter int unsigned SRAM_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic        id_use_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  output logic        freeze,
  output logic        hazard,
  output logic        flush,
  output logic        mem_stall,
  output logic        sram_start,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SRAM_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        exe_match, mem_match, raw;

  assign exe_match = exe_wb_en & ((id_use_src1 & (exe_dest == id_src1)) |
                                  (id_two_src  & (exe_dest == id_src2)));

`ifdef PIPE_CTRL_FWD_EN
  // ALU results are forwarded, so only a load still in EXE must stall decode.
  logic unused_mem_fields;
  assign unused_mem_fields = ^{mem_dest, mem_wb_en};
  assign raw = exe_match & exe_mem_read_en;
  assign mem_match = 1'b0;
`else
  logic unused_load_flag;
  assign unused_load_flag = exe_mem_read_en;
  assign mem_match = mem_wb_en & ((id_use_src1 & (mem_dest == id_src1)) |
                                  (id_two_src  & (mem_dest == id_src2)));
  assign raw = exe_match | mem_match;
`endif

  assign mem_stall  = (state_q == BUSY) & ~rst;
  assign sram_start = (state_q == IDLE) & mem_req & ~rst;
  assign hazard     = raw & ~branch_taken & ~mem_stall;
  assign flush      = branch_taken & ~mem_stall;
  assign freeze     = hazard | mem_stall;
  assign stall_count = stall_count_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (freeze && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; expectations adapt when PIPE_CTRL_FWD_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_use_src1, id_two_src, exe_wb_en, exe_mem_read_en, mem_wb_en;
  logic        branch_taken, mem_req;
  logic        freeze, hazard, flush, mem_stall, sram_start;
  logic [15:0] stall_count;
  logic        freeze1, hazard1, flush1, mem_stall1, sram_start1;
  logic [15:0] stall_count1;

  int vectors = 0;
  int miscompares = 0;

`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
  localparam logic [15:0] COUNT_AT_SAT_START = 16'd6;
`else
  localparam bit FWD = 1'b0;
  localparam logic [15:0] COUNT_AT_SAT_START = 16'd8;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.SRAM_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_use_src1(id_use_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read_en(exe_mem_read_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze(freeze), .hazard(hazard), .flush(flush), .mem_stall(mem_stall),
    .sram_start(sram_start), .stall_count(stall_count)
  );

  // Minimum-latency instance shares the stimulus; only its first accesses are checked.
  pipe_ctrl #(.SRAM_WAIT(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_use_src1(id_use_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read_en(exe_mem_read_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze(freeze1), .hazard(hazard1), .flush(flush1), .mem_stall(mem_stall1),
    .sram_start(sram_start1), .stall_count(stall_count1)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs are changed just after a rising edge; outputs are sampled on the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIds();
    id_src1 = 4'd0; id_use_src1 = 1'b0; id_src2 = 4'd0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    clearIds();
    rst = 1'b1;
    mem_req = 1'b1;
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read_en = 1'b1;
    nextCycle();
    applyStimulus();
    checkOutput("rst_mem_stall", {15'd0, mem_stall}, 16'd0);
    checkOutput("rst_sram_start", {15'd0, sram_start}, 16'd0);
    checkOutput("rst_hazard", {15'd0, hazard}, 16'd1);
    checkOutput("rst_stall_count", stall_count, 16'd0);

    // Cycle 0..6: back-to-back SRAM access with SRAM_WAIT=4.
    nextCycle();
    rst = 1'b0; clearIds(); mem_req = 1'b1;
    applyStimulus();
    checkOutput("c0_sram_start", {15'd0, sram_start}, 16'd1);
    checkOutput("c0_mem_stall", {15'd0, mem_stall}, 16'd0);
    checkOutput("c0_w1_sram_start", {15'd0, sram_start1}, 16'd1);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      applyStimulus();
      checkOutput($sformatf("c%0d_mem_stall", c), {15'd0, mem_stall}, 16'd1);
      checkOutput($sformatf("c%0d_sram_start", c), {15'd0, sram_start}, 16'd0);
      checkOutput($sformatf("c%0d_freeze", c), {15'd0, freeze}, 16'd1);
      if (c == 1) checkOutput("c1_w1_mem_stall", {15'd0, mem_stall1}, 16'd1);
      if (c == 2) checkOutput("c2_w1_mem_stall", {15'd0, mem_stall1}, 16'd0);
      if (c == 3) checkOutput("c3_w1_sram_start", {15'd0, sram_start1}, 16'd1);
    end
    nextCycle();
    applyStimulus();
    checkOutput("c5_done_mem_stall", {15'd0, mem_stall}, 16'd0);
    checkOutput("c5_done_sram_start", {15'd0, sram_start}, 16'd0);
    checkOutput("c5_stall_count", stall_count, 16'd4);
    nextCycle();
    applyStimulus();
    checkOutput("c6_idle_sram_start", {15'd0, sram_start}, 16'd1);

    // Cycles 7-8: reset lands on the second BUSY cycle.
    nextCycle();
    mem_req = 1'b0;
    applyStimulus();
    checkOutput("c7_busy", {15'd0, mem_stall}, 16'd1);
    nextCycle();
    rst = 1'b1;
    applyStimulus();
    checkOutput("c8_rst_mem_stall", {15'd0, mem_stall}, 16'd0);
    nextCycle();
    rst = 1'b0; mem_req = 1'b1;
    applyStimulus();
    checkOutput("c9_post_rst_mem_stall", {15'd0, mem_stall}, 16'd0);
    checkOutput("c9_post_rst_stall_count", stall_count, 16'd0);
    checkOutput("c9_fresh_sram_start", {15'd0, sram_start}, 16'd1);

    // Cycles 10-15: hazard and branch while BUSY, deferred flush, then branch+raw in IDLE.
    nextCycle();
    mem_req = 1'b0;
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read_en = 1'b1;
    applyStimulus();
    checkOutput("c10_hazard_masked", {15'd0, hazard}, 16'd0);
    checkOutput("c10_freeze", {15'd0, freeze}, 16'd1);
    for (int c = 11; c <= 13; c++) begin
      nextCycle();
      branch_taken = 1'b1;
      applyStimulus();
      checkOutput($sformatf("c%0d_flush_deferred", c), {15'd0, flush}, 16'd0);
    end
    nextCycle();
    applyStimulus();
    checkOutput("c14_done_flush", {15'd0, flush}, 16'd1);
    checkOutput("c14_done_hazard", {15'd0, hazard}, 16'd0);
    checkOutput("c14_stall_count", stall_count, 16'd4);
    nextCycle();
    applyStimulus();
    checkOutput("c15_branch_raw_flush", {15'd0, flush}, 16'd1);
    checkOutput("c15_branch_raw_hazard", {15'd0, hazard}, 16'd0);
    checkOutput("c15_branch_raw_freeze", {15'd0, freeze}, 16'd0);

    // Cycles 16-21: RAW detection in both builds.
    nextCycle();
    branch_taken = 1'b0; exe_mem_read_en = 1'b0;
    applyStimulus();
    checkOutput("c16_exe_alu_hazard", {15'd0, hazard}, FWD ? 16'd0 : 16'd1);
    checkOutput("c16_exe_alu_freeze", {15'd0, freeze}, FWD ? 16'd0 : 16'd1);
    nextCycle();
    exe_mem_read_en = 1'b1;
    applyStimulus();
    checkOutput("c17_exe_load_hazard", {15'd0, hazard}, 16'd1);
    nextCycle();
    exe_wb_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
    applyStimulus();
    checkOutput("c18_mem_hazard", {15'd0, hazard}, FWD ? 16'd0 : 16'd1);
    nextCycle();
    id_use_src1 = 1'b0; id_two_src = 1'b1; id_src2 = 4'd5; mem_wb_en = 1'b0;
    exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_read_en = 1'b1;
    applyStimulus();
    checkOutput("c19_src2_hazard", {15'd0, hazard}, 16'd1);
    nextCycle();
    exe_dest = 4'd6;
    applyStimulus();
    checkOutput("c20_no_match", {15'd0, hazard}, 16'd0);
    nextCycle();
    exe_dest = 4'd5; id_two_src = 1'b0;
    applyStimulus();
    checkOutput("c21_src2_unused", {15'd0, hazard}, 16'd0);

    // Long freeze drives the counter into saturation.
    nextCycle();
    id_two_src = 1'b1;
    applyStimulus();
    checkOutput("sat_start_count", stall_count, COUNT_AT_SAT_START);
    repeat (65534 - int'(COUNT_AT_SAT_START)) nextCycle();
    applyStimulus();
    checkOutput("sat_fffe", stall_count, 16'hFFFE);
    nextCycle();
    applyStimulus();
    checkOutput("sat_ffff", stall_count, 16'hFFFF);
    repeat (70000 - 65535 + int'(COUNT_AT_SAT_START)) nextCycle();
    applyStimulus();
    checkOutput("sat_hold", stall_count, 16'hFFFF);
    checkOutput("sat_freeze_still", {15'd0, freeze}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
